// File: rtl/riscm_pkg.sv
// Shared types and encodings for the RISC-machine instruction sequencer.
package riscm_pkg;

   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned REG_W    = 3;
   localparam int unsigned OPCODE_W = 3;
   localparam int unsigned OP_W     = 2;
   localparam int unsigned SHIFT_W  = 2;
   localparam int unsigned IMM8_W   = 8;

   // Sequencer states
   typedef enum logic [2:0] {
      WAIT      = 3'd0,
      DECODE    = 3'd1,
      GET_A     = 3'd2,
      GET_B     = 3'd3,
      EXEC      = 3'd4,
      WRITE_RD  = 3'd5,
      WRITE_IMM = 3'd6
   } state_t;

   // Opcode and op-field constants
   localparam logic [OPCODE_W-1:0] OPC_ALU    = 3'b101;
   localparam logic [OPCODE_W-1:0] OPC_MOV    = 3'b110;
   localparam logic [OP_W-1:0]     OP_MOV_REG = 2'b00;
   localparam logic [OP_W-1:0]     OP_MOV_IMM = 2'b10;
   localparam logic [OP_W-1:0]     OP_ADD     = 2'b00;
   localparam logic [OP_W-1:0]     OP_CMP     = 2'b01;
   localparam logic [OP_W-1:0]     OP_AND     = 2'b10;
   localparam logic [OP_W-1:0]     OP_MVN     = 2'b11;

   // ALU operation encoding driven on ALUop
   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_SUB  = 2'b01,
      ALU_AND  = 2'b10,
      ALU_NOTB = 2'b11
   } aluop_t;

   // Write-back source select
   typedef enum logic [1:0] {
      VSEL_C   = 2'b00,
      VSEL_IMM = 2'b01
   } vsel_t;

   // Instruction classes that steer the sequencer out of DECODE
   typedef enum logic [2:0] {
      CLS_ILLEGAL = 3'd0,
      CLS_MOV_IMM = 3'd1,
      CLS_MOV_REG = 3'd2,
      CLS_MVN     = 3'd3,
      CLS_ALU     = 3'd4,
      CLS_CMP     = 3'd5
   } iclass_t;

   // Fields extracted from an instruction word
   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [OP_W-1:0]     op;
      logic [REG_W-1:0]    rn;
      logic [REG_W-1:0]    rd;
      logic [SHIFT_W-1:0]  shift;
      logic [REG_W-1:0]    rm;
      logic [DATA_W-1:0]   sximm8;
   } fields_t;

   // Datapath control bundle produced each cycle
   typedef struct packed {
      logic             w;
      logic [REG_W-1:0] readnum;
      logic [REG_W-1:0] writenum;
      logic             write;
      vsel_t            vsel;
      logic             loada;
      logic             loadb;
      logic             loadc;
      logic             loads;
      logic             asel;
      aluop_t           aluop;
      logic             err;
   } ctrl_t;

   // Map opcode/op onto an instruction class
   function automatic iclass_t classify(input logic [OPCODE_W-1:0] opcode,
                                        input logic [OP_W-1:0] op);
      iclass_t cls;
      cls = CLS_ILLEGAL;
      if (opcode == OPC_MOV) begin
         if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
         else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
      end else if (opcode == OPC_ALU) begin
         if (op == OP_ADD || op == OP_AND) cls = CLS_ALU;
         else if (op == OP_CMP)            cls = CLS_CMP;
         else if (op == OP_MVN)            cls = CLS_MVN;
      end
      return cls;
   endfunction

   // Control values while idle: ready, everything else off
   function automatic ctrl_t idle_ctrl();
      ctrl_t c;
      c   = '0;
      c.w = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational field extraction and imm8 sign extension.
module instr_decoder
   import riscm_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output fields_t            fields
);

   // Slice the fixed 16-bit format and sign-extend imm8
   always_comb begin
      fields        = '0;
      fields.opcode = instr[15:13];
      fields.op     = instr[12:11];
      fields.rn     = instr[10:8];
      fields.rd     = instr[7:5];
      fields.shift  = instr[4:3];
      fields.rm     = instr[2:0];
      fields.sximm8 = {{(DATA_W-IMM8_W){instr[IMM8_W-1]}}, instr[IMM8_W-1:0]};
   end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer: holds the IR, steps the FSM and drives datapath controls.
// Controls are computed from the next state/IR and registered, so they read as
// pure Moore outputs of the current state and IR.
module alu_sequencer
   import riscm_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                s,
   input  logic [INSTR_W-1:0]  instr,
   output logic                w,
   output logic [REG_W-1:0]    readnum,
   output logic [REG_W-1:0]    writenum,
   output logic                write,
   output logic [1:0]          vsel,
   output logic                loada,
   output logic                loadb,
   output logic                loadc,
   output logic                loads,
   output logic                asel,
   output logic [1:0]          ALUop,
   output logic [SHIFT_W-1:0]  shift,
   output logic [DATA_W-1:0]   sximm8,
   output logic                err
);

   state_t               state, state_next;
   logic [INSTR_W-1:0]   ir, ir_next;
   fields_t              fields;
   iclass_t              cls;
   ctrl_t                ctrl_next, ctrl_q;
   logic [SHIFT_W-1:0]   shift_q;
   logic [DATA_W-1:0]    sximm8_q;

   // Fields of the IR as it will be after this edge (equal to the IR outside WAIT)
   instr_decoder u_dec (
      .instr  (ir_next),
      .fields (fields)
   );

   assign cls = classify(fields.opcode, fields.op);

   // IR capture: only a start in WAIT loads a new instruction
   always_comb begin
      ir_next = ir;
      if (state == WAIT && s) ir_next = instr;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         WAIT:      if (s) state_next = DECODE;
         DECODE: begin
            case (cls)
               CLS_MOV_IMM:          state_next = WRITE_IMM;
               CLS_MOV_REG, CLS_MVN: state_next = GET_B;
               CLS_ALU, CLS_CMP:     state_next = GET_A;
               default:              state_next = WAIT;
            endcase
         end
         GET_A:     state_next = GET_B;
         GET_B:     state_next = EXEC;
         EXEC:      state_next = (cls == CLS_CMP) ? WAIT : WRITE_RD;
         WRITE_RD:  state_next = WAIT;
         WRITE_IMM: state_next = WAIT;
         default:   state_next = WAIT;
      endcase
   end

   // Control decode for the state about to be entered
   always_comb begin
      ctrl_next = '0;
      case (state_next)
         WAIT:   ctrl_next.w = 1'b1;
         DECODE: ctrl_next.err = (cls == CLS_ILLEGAL);
         GET_A: begin
            ctrl_next.readnum = fields.rn;
            ctrl_next.loada   = 1'b1;
         end
         GET_B: begin
            ctrl_next.readnum = fields.rm;
            ctrl_next.loadb   = 1'b1;
         end
         EXEC: begin
            ctrl_next.loadc = (cls != CLS_CMP);
            ctrl_next.loads = (cls == CLS_CMP);
            ctrl_next.asel  = (cls == CLS_MOV_REG);
            ctrl_next.aluop = (cls == CLS_MOV_REG) ? ALU_ADD : aluop_t'(fields.op);
         end
         WRITE_RD: begin
            ctrl_next.writenum = fields.rd;
            ctrl_next.vsel     = VSEL_C;
            ctrl_next.write    = 1'b1;
         end
         WRITE_IMM: begin
            ctrl_next.writenum = fields.rn;
            ctrl_next.vsel     = VSEL_IMM;
            ctrl_next.write    = 1'b1;
         end
         default: ctrl_next = '0;
      endcase
   end

   // State, IR and registered outputs; reset aborts any instruction in flight
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= WAIT;
         ir       <= '0;
         ctrl_q   <= idle_ctrl();
         shift_q  <= '0;
         sximm8_q <= '0;
      end else begin
         state    <= state_next;
         ir       <= ir_next;
         ctrl_q   <= ctrl_next;
         shift_q  <= fields.shift;
         sximm8_q <= fields.sximm8;
      end
   end

   assign w        = ctrl_q.w;
   assign readnum  = ctrl_q.readnum;
   assign writenum = ctrl_q.writenum;
   assign write    = ctrl_q.write;
   assign vsel     = ctrl_q.vsel;
   assign loada    = ctrl_q.loada;
   assign loadb    = ctrl_q.loadb;
   assign loadc    = ctrl_q.loadc;
   assign loads    = ctrl_q.loads;
   assign asel     = ctrl_q.asel;
   assign ALUop    = ctrl_q.aluop;
   assign err      = ctrl_q.err;
   assign shift    = shift_q;
   assign sximm8   = sximm8_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Cycle-accurate scoreboard bench for alu_sequencer.
module tb_alu_sequencer;

   logic        clk;
   logic        reset_n;
   logic        s;
   logic [15:0] instr;
   logic        w;
   logic [2:0]  readnum, writenum;
   logic        write;
   logic [1:0]  vsel;
   logic        loada, loadb, loadc, loads, asel;
   logic [1:0]  ALUop, shift;
   logic [15:0] sximm8;
   logic        err;

   typedef struct packed {
      logic        w;
      logic [2:0]  readnum;
      logic [2:0]  writenum;
      logic        write;
      logic [1:0]  vsel;
      logic        loada;
      logic        loadb;
      logic        loadc;
      logic        loads;
      logic        asel;
      logic [1:0]  aluop;
      logic [1:0]  shift;
      logic [15:0] sximm8;
      logic        err;
   } obs_t;

   obs_t  exp_q[$];
   string tag_q[$];
   int    tests = 0;
   int    fails = 0;

   alu_sequencer dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .s        (s),
      .instr    (instr),
      .w        (w),
      .readnum  (readnum),
      .writenum (writenum),
      .write    (write),
      .vsel     (vsel),
      .loada    (loada),
      .loadb    (loadb),
      .loadc    (loadc),
      .loads    (loads),
      .asel     (asel),
      .ALUop    (ALUop),
      .shift    (shift),
      .sximm8   (sximm8),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t sample();
      obs_t o;
      o.w = w; o.readnum = readnum; o.writenum = writenum; o.write = write;
      o.vsel = vsel; o.loada = loada; o.loadb = loadb; o.loadc = loadc;
      o.loads = loads; o.asel = asel; o.aluop = ALUop; o.shift = shift;
      o.sximm8 = sximm8; o.err = err;
      return o;
   endfunction

   // Idle-cycle expectation for a given IR content
   function automatic obs_t idle_exp(input logic [15:0] ir);
      obs_t o;
      o        = '0;
      o.w      = 1'b1;
      o.shift  = ir[4:3];
      o.sximm8 = {{8{ir[7]}}, ir[7:0]};
      return o;
   endfunction

   function automatic void push(input obs_t o, input string tag);
      exp_q.push_back(o);
      tag_q.push_back(tag);
   endfunction

   // Expected per-cycle trace from the edge after capture up to and including the WAIT cycle
   function automatic void push_instr(input logic [15:0] ins);
      obs_t b, o;
      logic [2:0] opc, rn, rd, rm;
      logic [1:0] op;
      logic movi, movr, mvn, cmp, arith;
      string id;
      opc = ins[15:13]; op = ins[12:11];
      rn = ins[10:8]; rd = ins[7:5]; rm = ins[2:0];
      movi  = (opc == 3'b110) && (op == 2'b10);
      movr  = (opc == 3'b110) && (op == 2'b00);
      mvn   = (opc == 3'b101) && (op == 2'b11);
      cmp   = (opc == 3'b101) && (op == 2'b01);
      arith = (opc == 3'b101) && (op == 2'b00 || op == 2'b10);
      id = $sformatf("%h", ins);
      b = idle_exp(ins);
      b.w = 1'b0;
      o = b; o.err = !(movi | movr | mvn | cmp | arith);
      push(o, {id, "/decode"});
      if (arith | cmp) begin
         o = b; o.readnum = rn; o.loada = 1'b1;
         push(o, {id, "/get_a"});
      end
      if (movr | mvn | arith | cmp) begin
         o = b; o.readnum = rm; o.loadb = 1'b1;
         push(o, {id, "/get_b"});
         o = b;
         o.loads = cmp; o.loadc = !cmp; o.asel = movr;
         o.aluop = movr ? 2'b00 : op;
         push(o, {id, "/exec"});
      end
      if (movr | mvn | arith) begin
         o = b; o.writenum = rd; o.vsel = 2'b00; o.write = 1'b1;
         push(o, {id, "/write_rd"});
      end
      if (movi) begin
         o = b; o.writenum = rn; o.vsel = 2'b01; o.write = 1'b1;
         push(o, {id, "/write_imm"});
      end
      push(idle_exp(ins), {id, "/wait"});
   endfunction

   // Advance one cycle and compare the DUT against the oldest expectation
   task automatic step_check();
      obs_t o, e;
      string t;
      @(posedge clk);
      #1;
      o = sample();
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $error("FAIL underflow: observed=%h required=<none>", o);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed=%h required=%h", t, o, e);
         end
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() > 0 && guard < 16) begin
         step_check();
         guard++;
      end
   endtask

   task automatic do_instr(input logic [15:0] ins, input logic hold_s);
      instr = ins;
      s     = 1'b1;
      push_instr(ins);
      step_check();
      if (!hold_s) s = 1'b0;
      drain();
   endtask

   logic [15:0] rnd_ins;
   logic [4:0]  kinds[6];

   initial begin
      kinds[0] = 5'b110_10; kinds[1] = 5'b110_00; kinds[2] = 5'b101_11;
      kinds[3] = 5'b101_00; kinds[4] = 5'b101_01; kinds[5] = 5'b101_10;
      reset_n = 1'b0;
      s       = 1'b1;
      instr   = 16'hD1F0;

      // Reset dominates a pending start
      push(idle_exp(16'h0000), "reset_hold");
      step_check();
      reset_n = 1'b0; s = 1'b0;
      push(idle_exp(16'h0000), "reset_hold2");
      step_check();
      reset_n = 1'b1;
      push(idle_exp(16'h0000), "after_reset");
      step_check();

      // Directed instructions
      do_instr(16'hD1F0, 1'b0);   // MOV R1, #-16
      do_instr(16'hA0A2, 1'b0);   // ADD R5, R0, R2
      do_instr(16'hA961, 1'b0);   // CMP R1, R1
      do_instr(16'hE000, 1'b0);   // illegal opcode
      do_instr(16'hC800, 1'b0);   // illegal MOV variant
      do_instr(16'hC0FD, 1'b0);   // MOV R7, R5 with shift
      do_instr(16'hB346, 1'b0);   // AND R2, R3, R6
      do_instr(16'h1234, 1'b0);   // illegal opcode 000

      // Reset in GET_B of an ADD: no write, back to WAIT with a cleared IR
      instr = 16'hA0A2;
      s     = 1'b1;
      push_instr(16'hA0A2);
      step_check();               // DECODE
      s = 1'b0;
      step_check();               // GET_A
      step_check();               // GET_B
      reset_n = 1'b0;
      exp_q.delete();
      tag_q.delete();
      push(idle_exp(16'h0000), "abort_reset");
      step_check();
      reset_n = 1'b1;
      push(idle_exp(16'h0000), "abort_idle");
      step_check();

      // MVN with s held and instr changed mid-flight, then immediate re-capture
      instr = 16'hB86C;
      s     = 1'b1;
      push_instr(16'hB86C);
      step_check();
      step_check();
      instr = 16'hA0A2;
      drain();
      do_instr(16'hA0A2, 1'b0);

      // Randomised operand fields over every legal class
      for (int k = 0; k < 12; k++) begin
         rnd_ins = {kinds[k % 6], 11'($urandom)};
         do_instr(rnd_ins, 1'b0);
      end

      tests++;
      assert (exp_q.size() === 0) else begin
         fails++;
         $error("FAIL leftover: observed=%0d entries required=0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
